// File: rtl/codec_config_sequencer.sv
// WM8731 power-up configuration sequencer: walks an 11-entry register table,
// one 24-bit I2C write per entry, with ACK-slot checking, timeout and retry.
module codec_config_sequencer #(
    parameter logic [7:0] DEV_ADDR   = 8'h34,
    parameter int         ACK_SLOT0  = 10,
    parameter int         ACK_SLOT1  = 19,
    parameter int         ACK_SLOT2  = 28,
    parameter int         TIMEOUT    = 40,
    parameter int         GAP_CYCLES = 4,
    parameter int         MAX_RETRY  = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    output logic [23:0] I2C_DATA,
    output logic        I2C_ACTIVATE,
    output logic        I2C_RESET,
    input  logic        I2C_END,
    input  logic        I2C_ACK,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERROR,
    output logic [3:0]  IDX
);

    localparam int         CW   = $clog2(TIMEOUT + 1);
    localparam logic [3:0] LAST = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_XFER, S_GAP, S_CHECK, S_DONE, S_FAIL
    } state_t;

    state_t          state_q, state_d;
    logic [23:0]     data_q, data_d;
    logic [3:0]      idx_q, idx_d;
    logic [1:0]      retry_q, retry_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic            nack_q, nack_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            act_q, act_d;
    logic            srst_q, srst_d;
    logic            at_slot;

    function automatic logic [15:0] reg_table(input logic [3:0] i);
        case (i)
            4'd0:    return 16'h1E00;
            4'd1:    return 16'h0097;
            4'd2:    return 16'h0297;
            4'd3:    return 16'h0479;
            4'd4:    return 16'h0679;
            4'd5:    return 16'h0815;
            4'd6:    return 16'h0A00;
            4'd7:    return 16'h0C00;
            4'd8:    return 16'h0E42;
            4'd9:    return 16'h1000;
            4'd10:   return 16'h1201;
            default: return 16'h0000;
        endcase
    endfunction

    assign at_slot = (cyc_q == CW'(ACK_SLOT0)) || (cyc_q == CW'(ACK_SLOT1)) ||
                     (cyc_q == CW'(ACK_SLOT2));

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        cyc_d   = cyc_q;
        nack_d  = nack_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (START) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    retry_d = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                data_d  = {DEV_ADDR, reg_table(idx_q)};
                cyc_d   = '0;
                nack_d  = 1'b0;
                state_d = S_XFER;
            end
            S_XFER: begin
                cyc_d = cyc_q + CW'(1);
                if (at_slot && I2C_ACK)
                    nack_d = 1'b1;
                // END on the last allowed cycle still counts as a clean finish
                if (I2C_END) begin
                    state_d = S_GAP;
                    cyc_d   = '0;
                end else if (cyc_q == CW'(TIMEOUT - 1)) begin
                    nack_d  = 1'b1;
                    state_d = S_GAP;
                    cyc_d   = '0;
                end
            end
            S_GAP: begin
                if (cyc_q == CW'(GAP_CYCLES - 1)) begin
                    cyc_d   = '0;
                    state_d = S_CHECK;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            S_CHECK: begin
                if (nack_q) begin
                    if (retry_q == 2'(MAX_RETRY)) begin
                        err_d   = 1'b1;
                        state_d = S_FAIL;
                    end else begin
                        retry_d = retry_q + 2'd1;
                        state_d = S_LOAD;
                    end
                end else if (idx_q == LAST) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    retry_d = '0;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Status outputs track the state being entered so they stay registered
        busy_d = (state_d == S_LOAD) || (state_d == S_XFER) ||
                 (state_d == S_GAP)  || (state_d == S_CHECK);
        act_d  = (state_d == S_XFER);
        srst_d = (state_d != S_XFER);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            retry_q <= '0;
            cyc_q   <= '0;
            nack_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            act_q   <= 1'b0;
            srst_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            cyc_q   <= cyc_d;
            nack_q  <= nack_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            act_q   <= act_d;
            srst_q  <= srst_d;
        end
    end

    assign I2C_DATA     = data_q;
    assign I2C_ACTIVATE = act_q;
    assign I2C_RESET    = srst_q;
    assign BUSY         = busy_q;
    assign DONE         = done_q;
    assign ERROR        = err_q;
    assign IDX          = idx_q;

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Bench for codec_config_sequencer: a serializer responder driven by per-entry
// plans, and a transaction-level model of the expected write sequence.
module tb_codec_config_sequencer;

    logic        CLK, RESET, START, I2C_END, I2C_ACK;
    logic [23:0] I2C_DATA;
    logic        I2C_ACTIVATE, I2C_RESET, BUSY, DONE, ERROR;
    logic [3:0]  IDX;

    codec_config_sequencer dut (
        .CLK(CLK), .RESET(RESET), .START(START),
        .I2C_DATA(I2C_DATA), .I2C_ACTIVATE(I2C_ACTIVATE), .I2C_RESET(I2C_RESET),
        .I2C_END(I2C_END), .I2C_ACK(I2C_ACK),
        .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .IDX(IDX)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    logic [15:0] TABLE [11] = '{16'h1E00, 16'h0097, 16'h0297, 16'h0479, 16'h0679,
                                16'h0815, 16'h0A00, 16'h0C00, 16'h0E42, 16'h1000,
                                16'h1201};

    // Per-entry serializer behaviour; end_at >= 40 means END never comes
    int end_at [11];
    int nack_att [11];
    int nack_cyc [11];
    int noise_cyc [11];

    logic [23:0] obs_data [$];
    int          obs_len [$];
    int          att_cnt [11];

    logic [23:0] exp_data [$];
    int          exp_len [$];
    int          exp_cycles;
    bit          exp_err;
    int          exp_idx;

    int checks = 0;
    int errors = 0;
    int w_ign;

    // Responder: plays the serializer, logs every transaction it sees
    initial begin
        int k, cur, att;
        bit prev_act, prev_busy;
        k = 0; cur = 0; att = 0; prev_act = 0; prev_busy = 0;
        I2C_END = 1'b0;
        I2C_ACK = 1'b0;
        forever begin
            @(negedge CLK);
            if (BUSY && !prev_busy) begin
                obs_data.delete();
                obs_len.delete();
                foreach (att_cnt[i]) att_cnt[i] = 0;
            end
            if (I2C_ACTIVATE) begin
                if (!prev_act) begin
                    k = 0;
                    cur = (int'(IDX) > 10) ? 10 : int'(IDX);
                    att = att_cnt[cur];
                    att_cnt[cur]++;
                    obs_data.push_back(I2C_DATA);
                end else begin
                    k++;
                end
                I2C_END = (k == end_at[cur]);
                I2C_ACK = ((att < nack_att[cur]) && (k == nack_cyc[cur])) || (k == noise_cyc[cur]);
            end else begin
                if (prev_act) obs_len.push_back(k + 1);
                I2C_END = 1'b0;
                I2C_ACK = 1'b0;
            end
            prev_act  = I2C_ACTIVATE;
            prev_busy = BUSY;
        end
    end

    function automatic bit is_slot(input int c);
        return (c == 10) || (c == 19) || (c == 28);
    endfunction

    // Attempt-by-attempt expectation: an attempt fails on a slot NACK seen
    // before END, or when END never arrives within 40 cycles.
    function automatic void build_model();
        int len;
        bit bad, ok;
        exp_data.delete();
        exp_len.delete();
        exp_cycles = 0;
        exp_err = 0;
        exp_idx = 10;
        for (int i = 0; i < 11; i++) begin
            ok = 0;
            for (int a = 0; a < 4 && !ok; a++) begin
                len = (end_at[i] < 40) ? end_at[i] + 1 : 40;
                bad = (end_at[i] >= 40);
                if (a < nack_att[i] && is_slot(nack_cyc[i]) && nack_cyc[i] < len) bad = 1;
                if (is_slot(noise_cyc[i]) && noise_cyc[i] < len) bad = 1;
                exp_data.push_back({8'h34, TABLE[i]});
                exp_len.push_back(len);
                exp_cycles += len + 6;
                ok = !bad;
            end
            if (!ok) begin
                exp_err = 1;
                exp_idx = i;
                return;
            end
        end
    endfunction

    function automatic logic [6:0] exp_flags();
        return {~exp_err, exp_err, 1'b0, 4'(exp_idx)};
    endfunction

    function automatic int first_diff();
        if (obs_data.size() != exp_data.size() || obs_len.size() != exp_len.size()) return -2;
        foreach (exp_data[i])
            if (obs_data[i] !== exp_data[i] || obs_len[i] != exp_len[i]) return i;
        return -1;
    endfunction

    task automatic clean_plan();
        foreach (end_at[i]) begin
            end_at[i] = 29; nack_att[i] = 0; nack_cyc[i] = -1; noise_cyc[i] = -1;
        end
    endtask

    task automatic run_seq(output int n);
        build_model();
        @(negedge CLK); START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
        n = 0;
        while (BUSY && n < 4000) begin
            @(posedge CLK); #1;
            n++;
        end
        @(negedge CLK); @(negedge CLK);
    endtask

    task automatic test_reset();
        RESET = 1'b1; START = 1'b0;
        #12;
        checks++;
        if ({I2C_ACTIVATE, I2C_RESET} !== 2'b01) begin
            errors++; $display("FAIL reset_ser act/rst got %b want 01", {I2C_ACTIVATE, I2C_RESET});
        end
        checks++;
        if ({BUSY, DONE, ERROR, IDX} !== 7'd0) begin
            errors++; $display("FAIL reset_status got %b want 0000000", {BUSY, DONE, ERROR, IDX});
        end
        checks++;
        if (I2C_DATA !== 24'h0) begin
            errors++; $display("FAIL reset_data got %h want 000000", I2C_DATA);
        end
        @(negedge CLK); RESET = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_happy();
        int n;
        clean_plan();
        run_seq(n);
        checks++;
        if (first_diff() != -1) begin
            errors++; $display("FAIL happy_tx diff at %0d ntx %0d want %0d", first_diff(), obs_data.size(), exp_data.size());
        end
        checks++;
        if (n != exp_cycles) begin errors++; $display("FAIL happy_cycles got %0d want %0d", n, exp_cycles); end
        checks++;
        if ({DONE, ERROR, BUSY, IDX} !== exp_flags()) begin
            errors++; $display("FAIL happy_flags got %b want %b", {DONE, ERROR, BUSY, IDX}, exp_flags());
        end
    endtask

    task automatic test_single_nack();
        int n;
        clean_plan();
        nack_att[3] = 1; nack_cyc[3] = 19;
        run_seq(n);
        checks++;
        if (first_diff() != -1 || obs_data.size() != 12) begin
            errors++; $display("FAIL nack1_tx diff at %0d ntx %0d want 12", first_diff(), obs_data.size());
        end
        checks++;
        if (n != exp_cycles) begin errors++; $display("FAIL nack1_cycles got %0d want %0d", n, exp_cycles); end
        checks++;
        if ({DONE, ERROR, BUSY, IDX} !== 7'b1000000 + 7'd10) begin
            errors++; $display("FAIL nack1_flags got %b want %b", {DONE, ERROR, BUSY, IDX}, 7'b1001010);
        end
    endtask

    task automatic test_persistent_nack();
        int n;
        clean_plan();
        nack_att[3] = 4; nack_cyc[3] = 10;
        run_seq(n);
        checks++;
        if (first_diff() != -1 || obs_data.size() != 7) begin
            errors++; $display("FAIL nack4_tx diff at %0d ntx %0d want 7", first_diff(), obs_data.size());
        end
        checks++;
        if (n != exp_cycles) begin errors++; $display("FAIL nack4_cycles got %0d want %0d", n, exp_cycles); end
        checks++;
        if ({DONE, ERROR, BUSY, IDX} !== 7'b0100011) begin
            errors++; $display("FAIL nack4_flags got %b want 0100011", {DONE, ERROR, BUSY, IDX});
        end
        clean_plan();
        build_model();
        @(negedge CLK); START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
        checks++;
        if ({DONE, ERROR, BUSY, IDX} !== 7'b0010000) begin
            errors++; $display("FAIL restart_after_fail got %b want 0010000", {DONE, ERROR, BUSY, IDX});
        end
        n = 0;
        while (BUSY && n < 4000) begin @(posedge CLK); #1; n++; end
        @(negedge CLK); @(negedge CLK);
        checks++;
        if (first_diff() != -1 || {DONE, ERROR, IDX} !== 6'b101010) begin
            errors++; $display("FAIL restart_run diff %0d flags %b want 101010", first_diff(), {DONE, ERROR, IDX});
        end
    endtask

    task automatic test_timeout();
        int n;
        clean_plan();
        end_at[0] = 40;
        run_seq(n);
        checks++;
        if (first_diff() != -1 || obs_len.size() != 4) begin
            errors++; $display("FAIL timeout_tx diff at %0d nlen %0d want 4 of 40", first_diff(), obs_len.size());
        end
        checks++;
        if (n != 184) begin errors++; $display("FAIL timeout_cycles got %0d want 184", n); end
        checks++;
        if ({DONE, ERROR, BUSY, IDX} !== 7'b0100000) begin
            errors++; $display("FAIL timeout_flags got %b want 0100000", {DONE, ERROR, BUSY, IDX});
        end
    endtask

    task automatic test_reset_mid();
        int n;
        clean_plan();
        @(negedge CLK); START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
        n = 0;
        while (!(IDX == 4'd5 && I2C_ACTIVATE) && n < 3000) begin @(posedge CLK); #1; n++; end
        checks++;
        if (n >= 3000) begin errors++; $display("FAIL midrst_reach idx %0d want 5", IDX); end
        repeat (7) @(posedge CLK);
        #2 RESET = 1'b1;
        #1;
        checks++;
        if ({I2C_ACTIVATE, I2C_RESET} !== 2'b01) begin
            errors++; $display("FAIL midrst_async act/rst got %b want 01", {I2C_ACTIVATE, I2C_RESET});
        end
        checks++;
        if ({BUSY, DONE, ERROR, IDX} !== 7'd0 || I2C_DATA !== 24'h0) begin
            errors++; $display("FAIL midrst_state got %b data %h want 0", {BUSY, DONE, ERROR, IDX}, I2C_DATA);
        end
        @(negedge CLK); RESET = 1'b0;
        repeat (20) @(posedge CLK);
        #1;
        checks++;
        if ({BUSY, I2C_ACTIVATE, I2C_RESET, IDX} !== 7'b0010000) begin
            errors++; $display("FAIL midrst_idle got %b want 0010000", {BUSY, I2C_ACTIVATE, I2C_RESET, IDX});
        end
    endtask

    task automatic test_start_ignored();
        int n;
        clean_plan();
        w_ign = 0;
        fork
            run_seq(n);
            begin
                @(posedge CLK); #1;
                while (!(IDX == 4'd2 && I2C_ACTIVATE) && w_ign < 3000) begin
                    @(posedge CLK); #1; w_ign++;
                end
                repeat (5) @(negedge CLK);
                START = 1'b1;
                @(negedge CLK); START = 1'b0;
            end
        join
        checks++;
        if (w_ign >= 3000) begin errors++; $display("FAIL ign_reach idx %0d want 2", IDX); end
        checks++;
        if (first_diff() != -1 || n != exp_cycles) begin
            errors++; $display("FAIL ign_run diff %0d cycles %0d want %0d", first_diff(), n, exp_cycles);
        end
        @(negedge CLK); START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
        checks++;
        if ({DONE, BUSY, IDX} !== 6'b010000) begin
            errors++; $display("FAIL rerun_from_done got %b want 010000", {DONE, BUSY, IDX});
        end
        n = 0;
        while (BUSY && n < 4000) begin @(posedge CLK); #1; n++; end
        checks++;
        if ({DONE, ERROR, IDX} !== 6'b101010) begin
            errors++; $display("FAIL rerun_done got %b want 101010", {DONE, ERROR, IDX});
        end
    endtask

    task automatic test_random();
        int n, r;
        for (int it = 0; it < 6; it++) begin
            foreach (end_at[i]) begin
                end_at[i]    = ($urandom_range(0, 5) == 0) ? int'($urandom_range(28, 40)) : 29;
                nack_att[i]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
                r            = $urandom_range(0, 3);
                nack_cyc[i]  = (r == 0) ? 10 : (r == 1) ? 19 : (r == 2) ? 28 : int'($urandom_range(0, 27));
                noise_cyc[i] = int'($urandom_range(0, 27));
                if (is_slot(noise_cyc[i])) noise_cyc[i] = noise_cyc[i] + 1;
            end
            run_seq(n);
            checks++;
            if (first_diff() != -1) begin
                errors++; $display("FAIL rand%0d_tx diff at %0d ntx %0d want %0d", it, first_diff(), obs_data.size(), exp_data.size());
            end
            checks++;
            if (n != exp_cycles) begin errors++; $display("FAIL rand%0d_cycles got %0d want %0d", it, n, exp_cycles); end
            checks++;
            if ({DONE, ERROR, BUSY, IDX} !== exp_flags()) begin
                errors++; $display("FAIL rand%0d_flags got %b want %b", it, {DONE, ERROR, BUSY, IDX}, exp_flags());
            end
        end
    endtask

    initial begin
        clean_plan();
        test_reset();
        test_happy();
        test_single_nack();
        test_persistent_nack();
        test_timeout();
        test_reset_mid();
        test_start_ignored();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/codec_config_sequencer.md
Name: codec_config_sequencer

Overview:
- Drives the 24-bit I2C serializer to configure the WM8731 audio codec after power-up or on request.
- Steps through an internal 11-entry register table, one I2C write transaction per entry.
- Checks the three acknowledge slots of every transaction and retries on NACK or timeout.
- Reports BUSY, DONE or ERROR to the top-level controller.

Parameters:
- DEV_ADDR, 8'h34: I2C device address byte (write), placed in I2C_DATA[23:16].
- ACK_SLOT0, 10: XFER cycle index at which I2C_ACK is sampled for the address byte ACK.
- ACK_SLOT1, 19: XFER cycle index for the register-byte ACK.
- ACK_SLOT2, 28: XFER cycle index for the data-byte ACK.
- TIMEOUT, 40: maximum XFER cycles to wait for I2C_END.
- GAP_CYCLES, 4: idle cycles between transactions, with I2C_ACTIVATE low.
- MAX_RETRY, 3: extra attempts per entry after the first failed attempt.

Ports:
- CLK, input, 1: system clock; all state updates on the rising edge.
- RESET, input, 1: asynchronous, active-high reset.
- START, input, 1: begin the sequence. Sampled only in IDLE, DONE or FAIL.
- I2C_DATA, output, 24: {DEV_ADDR, table[IDX]} presented to the serializer.
- I2C_ACTIVATE, output, 1: serializer enable.
- I2C_RESET, output, 1: serializer reset.
- I2C_END, input, 1: serializer end-of-transaction flag.
- I2C_ACK, input, 1: registered SDAT sample from the serializer. A 1 at an ACK slot is a NACK.
- BUSY, output, 1: sequence in progress.
- DONE, output, 1: all entries written; held until the next START.
- ERROR, output, 1: an entry exhausted its retries; held until the next START.
- IDX, output, 4: current entry, or the failing entry in FAIL.

Behaviour:
- Register table, entries 0..10 (16 bits each):
  - 0: 1E00
  - 1: 0097
  - 2: 0297
  - 3: 0479
  - 4: 0679
  - 5: 0815
  - 6: 0A00
  - 7: 0C00
  - 8: 0E42
  - 9: 1000
  - 10: 1201
  - LAST=10.
- Output timing: all outputs are registered.
- Reset values: state IDLE, I2C_DATA=0, I2C_ACTIVATE=0, I2C_RESET=1, BUSY=0, DONE=0, ERROR=0, IDX=0, retry=0, cyc=0, nack=0.
- I2C_RESET is 1 in every state except XFER, so the serializer is held cleared between transactions.
- States: IDLE, LOAD, XFER, GAP, CHECK, DONE, FAIL.
- IDLE, DONE or FAIL with START=1 -> LOAD.
  - Set IDX=0, retry=0, BUSY=1.
  - Clear DONE and ERROR.
- START=0 in those states: remain there.
- START in any other state is ignored.
- LOAD (1 cycle):
  - I2C_DATA <= {DEV_ADDR, table[IDX]}.
  - cyc <= 0, nack <= 0.
  - Next state XFER.
- XFER:
  - I2C_ACTIVATE=1 and I2C_RESET=0.
  - cyc increments once per cycle; cyc=0 on the first XFER cycle.
  - If cyc equals ACK_SLOT0, ACK_SLOT1 or ACK_SLOT2 and I2C_ACK=1, set nack <= 1.
  - I2C_END=1 -> GAP.
  - Otherwise, cyc == TIMEOUT-1 -> nack <= 1 and go to GAP.
  - If I2C_END and the timeout coincide, END wins; no timeout NACK is added.
- GAP:
  - I2C_ACTIVATE=0.
  - Hold for GAP_CYCLES cycles, counted on cyc reloaded to 0 on entry.
  - Then go to CHECK.
- CHECK (1 cycle):
  - nack=1 and retry==MAX_RETRY -> FAIL with ERROR=1 and BUSY=0; IDX holds the failing entry.
  - nack=1 and retry<MAX_RETRY -> retry+1, then LOAD for the same IDX.
  - nack=0 and IDX==LAST -> DONE with DONE=1 and BUSY=0.
  - nack=0 and IDX<LAST -> IDX+1, retry=0, then LOAD.
- Cycles per successful entry: 1 (LOAD) + XFER cycles up to and including I2C_END + GAP_CYCLES + 1 (CHECK).
- IDX never exceeds LAST; there is no wrap-around.
- The retry counter is 2 bits wide and never exceeds MAX_RETRY.
- RESET asserted mid-transaction immediately forces all reset values:
  - I2C_ACTIVATE drops and I2C_RESET rises without waiting for a clock edge.
  - No automatic restart after RESET; START is required.
- DONE and ERROR are never asserted together.
- BUSY=1 exactly in LOAD, XFER, GAP and CHECK.

Test Plan:
- Happy path, model ACKs all 0, END at XFER cycle 29, START pulse -> I2C_DATA sequence 341E00, 340097, 340297, 340479, 340679, 340815, 340A00, 340C00, 340E42, 341000, 341201.
  - Then DONE=1, BUSY=0, ERROR=0, IDX=10.
- Single NACK, I2C_ACK=1 at XFER cycle 19 on the first attempt of IDX=3 only -> 340479 sent twice.
  - Sequence continues to DONE=1; 12 transactions total.
- Persistent NACK on IDX=3, I2C_ACK=1 at cycle 10 on every attempt -> 4 attempts of 340479.
  - Then ERROR=1, DONE=0, BUSY=0, IDX=3.
  - A following START restarts at IDX=0 with ERROR cleared.
- Timeout, I2C_END never asserted on IDX=0 -> each attempt lasts 40 XFER cycles.
  - After 4 attempts: ERROR=1, IDX=0.
- RESET pulse asynchronously mid-XFER on IDX=5 -> I2C_ACTIVATE=0 and I2C_RESET=1 before the next clock edge.
  - BUSY=0, IDX=0; stays IDLE until START.
- START pulsed during XFER of IDX=2 -> ignored; sequence proceeds unchanged to DONE.
  - START in DONE -> rerun from IDX=0 with DONE cleared.
